// File: rtl/rx_frame_if.sv
// Byte-in / frame-out bundle between UART_RX, the frame assembler and the FFT core.
// The slave modport is the assembler's view; the master modport is the producer/consumer side.
interface rx_frame_if #(
   parameter int FFT_SIZE    = 16,
   parameter int WORD_SIZE   = 16,
   parameter int DATA_LENGTH = 8
);
   logic [DATA_LENGTH-1:0]        i_byte;
   logic                          i_byte_valid;
   logic                          i_frame_ack;
   logic [FFT_SIZE*WORD_SIZE-1:0] o_samples;
   logic                          o_frame_valid;
   logic [5:0]                    o_byte_count;
   logic                          o_timeout;
   logic                          o_overrun;

   modport slave (
      input  i_byte, i_byte_valid, i_frame_ack,
      output o_samples, o_frame_valid, o_byte_count, o_timeout, o_overrun
   );

   modport master (
      output i_byte, i_byte_valid, i_frame_ack,
      input  o_samples, o_frame_valid, o_byte_count, o_timeout, o_overrun
   );
endinterface

// File: rtl/rx_frame_assembler.sv
// Packs UART bytes (low byte first) into FFT_SIZE samples and hands the frame to the FFT core
// with a valid/ack handshake; drops stalled partial frames and flags bytes lost while full.
module rx_frame_assembler #(
   parameter int FFT_SIZE       = 16,
   parameter int WORD_SIZE      = 16,
   parameter int DATA_LENGTH    = 8,
   parameter int TIMEOUT_CYCLES = 8680
) (
   input  logic      i_clk,
   input  logic      i_rst,
   rx_frame_if.slave bus
);
   localparam int              SW         = FFT_SIZE * WORD_SIZE;
   localparam int              TW         = $clog2(TIMEOUT_CYCLES);
   localparam logic [5:0]      LAST_BYTE  = 6'(2 * FFT_SIZE - 1);
   localparam logic [TW-1:0]   TMR_EXPIRE = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [TW-1:0]   TMR_MAX    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [SW-1:0]          samples_q, samples_d;
   logic                   valid_q, valid_d;
   logic [5:0]             count_q, count_d;
   logic                   timeout_q, timeout_d;
   logic                   overrun_q, overrun_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic [DATA_LENGTH-1:0] lo_q, lo_d;

   logic                   accept;
   logic                   wr_en;
   logic [5:0]             base;
   logic [4:0]             wr_idx;

   always_comb begin
      state_d   = state_q;
      samples_d = samples_q;
      valid_d   = valid_q;
      count_d   = count_q;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
      tmr_d     = tmr_q;
      lo_d      = lo_q;
      accept    = 1'b0;
      base      = count_q;

      case (state_q)
         FULL: begin
            // Ack wins over a coincident byte, which then opens the next frame.
            if (bus.i_frame_ack) begin
               state_d = COLLECT;
               valid_d = 1'b0;
               accept  = bus.i_byte_valid;
            end else if (bus.i_byte_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            accept = bus.i_byte_valid;
            if (count_q != 6'd0) begin
               if (tmr_q == TMR_EXPIRE) begin
                  timeout_d = 1'b1;
                  count_d   = 6'd0;
                  base      = 6'd0;
                  tmr_d     = '0;
               end else if (tmr_q != TMR_MAX) begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
         end
      endcase

      wr_en  = accept && base[0];
      wr_idx = base[5:1];

      if (accept) begin
         tmr_d = '0;
         if (!base[0]) begin
            lo_d    = bus.i_byte;
            count_d = base + 6'd1;
         end else if (base == LAST_BYTE) begin
            count_d = 6'd0;
            valid_d = 1'b1;
            state_d = FULL;
         end else begin
            count_d = base + 6'd1;
         end
      end

      for (int k = 0; k < FFT_SIZE; k++) begin
         if (wr_en && (wr_idx == k[4:0])) begin
            samples_d[k*WORD_SIZE +: WORD_SIZE] = {bus.i_byte, lo_q};
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= COLLECT;
         samples_q <= '0;
         valid_q   <= 1'b0;
         count_q   <= 6'd0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         tmr_q     <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         samples_q <= samples_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
         tmr_q     <= tmr_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.o_samples     = samples_q;
   assign bus.o_frame_valid = valid_q;
   assign bus.o_byte_count  = count_q;
   assign bus.o_timeout     = timeout_q;
   assign bus.o_overrun     = overrun_q;
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler: directed sequences, a vector table and random
// traffic, all compared every cycle against a queue-based frame model.
module tb_rx_frame_assembler;
   localparam int FFT  = 16;
   localparam int WS   = 16;
   localparam int DL   = 8;
   localparam int TO   = 100;
   localparam int SW   = FFT * WS;
   localparam int NB   = 2 * FFT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rx_frame_if #(.FFT_SIZE(FFT), .WORD_SIZE(WS), .DATA_LENGTH(DL)) bus ();

   rx_frame_assembler #(
      .FFT_SIZE(FFT), .WORD_SIZE(WS), .DATA_LENGTH(DL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes of the open frame in a queue, frame contents in an array.
   logic [7:0]  m_bytes[$];
   logic [15:0] m_samp[FFT];
   logic        m_full, m_valid, m_to, m_ov;
   int          m_idle;

   task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] model_samples();
      logic [SW-1:0] v;
      for (int k = 0; k < FFT; k++) v[k*WS +: WS] = m_samp[k];
      return v;
   endfunction

   task automatic model_reset();
      m_bytes.delete();
      for (int k = 0; k < FFT; k++) m_samp[k] = '0;
      m_full = 0; m_valid = 0; m_to = 0; m_ov = 0; m_idle = 0;
   endtask

   task automatic model_push(input logic [7:0] b);
      int n;
      m_bytes.push_back(b);
      m_idle = 0;
      n = m_bytes.size();
      if (n % 2 == 0) m_samp[n/2 - 1] = {m_bytes[n-1], m_bytes[n-2]};
      if (n == NB) begin
         m_full  = 1;
         m_valid = 1;
         m_bytes.delete();
      end
   endtask

   task automatic model_step(input logic v, input logic [7:0] b, input logic a, input logic r);
      m_to = 0;
      m_ov = 0;
      if (r) begin
         model_reset();
      end else if (m_full) begin
         if (a) begin
            m_full  = 0;
            m_valid = 0;
            if (v) model_push(b);
         end else if (v) begin
            m_ov = 1;
         end
      end else begin
         // A partial frame expires once TO-1 idle cycles have elapsed since its last byte.
         if (m_bytes.size() > 0 && m_idle + 1 == TO - 1) begin
            m_bytes.delete();
            m_to   = 1;
            m_idle = 0;
         end else if (m_bytes.size() > 0) begin
            m_idle++;
         end
         if (v) model_push(b);
      end
   endtask

   task automatic tick(input logic v, input logic [7:0] b, input logic a, input logic r);
      bus.i_byte_valid = v;
      bus.i_byte       = b;
      bus.i_frame_ack  = a;
      rst              = r;
      @(posedge clk);
      #1;
      model_step(v, b, a, r);
      chk("frame_valid", SW'(bus.o_frame_valid), SW'(m_valid));
      chk("byte_count",  SW'(bus.o_byte_count),  SW'(m_bytes.size()));
      chk("timeout",     SW'(bus.o_timeout),     SW'(m_to));
      chk("overrun",     SW'(bus.o_overrun),     SW'(m_ov));
      chk("samples",     bus.o_samples,          model_samples());
      bus.i_byte_valid = 1'b0;
      bus.i_frame_ack  = 1'b0;
      rst              = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < NB; i++) begin
         tick(1'b1, 8'($urandom), 1'b0, 1'b0);
         if (i < NB - 1) begin
            int g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            for (int j = 0; j < g; j++) tick(1'b0, 8'h00, 1'b0, 1'b0);
         end
      end
      chk("frame_done_valid", SW'(bus.o_frame_valid), SW'(1));
      chk("frame_done_count", SW'(bus.o_byte_count), SW'(0));
   endtask

   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       a;
      logic       exp_valid;
      logic [5:0] exp_count;
      logic       exp_ov;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW-1:0] held;
      logic [15:0]   s;
      int            got;

      tbl[0] = '{v: 1'b1, b: 8'hAA, a: 1'b1, exp_valid: 1'b0, exp_count: 6'd1, exp_ov: 1'b0};
      tbl[1] = '{v: 1'b1, b: 8'hBB, a: 1'b0, exp_valid: 1'b0, exp_count: 6'd2, exp_ov: 1'b0};
      tbl[2] = '{v: 1'b0, b: 8'h00, a: 1'b1, exp_valid: 1'b0, exp_count: 6'd2, exp_ov: 1'b0};
      tbl[3] = '{v: 1'b1, b: 8'hCC, a: 1'b0, exp_valid: 1'b0, exp_count: 6'd3, exp_ov: 1'b0};

      bus.i_byte = '0;
      bus.i_byte_valid = 1'b0;
      bus.i_frame_ack = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset state
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_samples", bus.o_samples, SW'(0));
      chk("rst_valid", SW'(bus.o_frame_valid), SW'(0));
      chk("rst_count", SW'(bus.o_byte_count), SW'(0));

      // Byte order: byte i = i, one strobe every 10 cycles
      for (int i = 0; i < NB; i++) begin
         tick(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == NB - 2) chk("order_not_yet_valid", SW'(bus.o_frame_valid), SW'(0));
         if (i < NB - 1) for (int j = 0; j < 9; j++) tick(1'b0, 8'h00, 1'b0, 1'b0);
      end
      chk("order_valid", SW'(bus.o_frame_valid), SW'(1));
      chk("order_count", SW'(bus.o_byte_count), SW'(0));
      s = bus.o_samples[0 +: 16];
      chk("order_sample0", SW'(s), SW'(16'h0100));
      s = bus.o_samples[16 +: 16];
      chk("order_sample1", SW'(s), SW'(16'h0302));
      s = bus.o_samples[15*16 +: 16];
      chk("order_sample15", SW'(s), SW'(16'h1F1E));

      // Frame pending 50 cycles, a lost byte, then ack
      held = bus.o_samples;
      for (int j = 0; j < 50; j++) tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pend_valid_held", SW'(bus.o_frame_valid), SW'(1));
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      chk("pend_overrun", SW'(bus.o_overrun), SW'(1));
      chk("pend_samples_frozen", bus.o_samples, held);
      chk("pend_count", SW'(bus.o_byte_count), SW'(0));
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pend_overrun_single", SW'(bus.o_overrun), SW'(0));
      chk("pend_valid_still", SW'(bus.o_frame_valid), SW'(1));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ack_valid_drop", SW'(bus.o_frame_valid), SW'(0));

      // Back-to-back strobes: 32 consecutive random bytes
      send_frame(0);

      // Simultaneous ack and byte, then an ack ignored while collecting
      foreach (tbl[i]) begin
         tick(tbl[i].v, tbl[i].b, tbl[i].a, 1'b0);
         chk($sformatf("tbl%0d_valid", i), SW'(bus.o_frame_valid), SW'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_count", i), SW'(bus.o_byte_count), SW'(tbl[i].exp_count));
         chk($sformatf("tbl%0d_overrun", i), SW'(bus.o_overrun), SW'(tbl[i].exp_ov));
      end
      s = bus.o_samples[0 +: 16];
      chk("simul_sample0", SW'(s), SW'(16'hBBAA));

      // Timeout: 5 bytes in the frame, then idle
      tick(1'b1, 8'hDD, 1'b0, 1'b0);
      tick(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("to_count5", SW'(bus.o_byte_count), SW'(5));
      got = -1;
      for (int k = 1; k <= 3 * TO; k++) begin
         tick(1'b0, 8'h00, 1'b0, 1'b0);
         if (bus.o_timeout) begin
            got = k;
            break;
         end
      end
      chk("to_latency", SW'(got), SW'(TO - 1));
      chk("to_count0", SW'(bus.o_byte_count), SW'(0));
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_single_pulse", SW'(bus.o_timeout), SW'(0));
      send_frame(3);
      tick(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-frame
      for (int i = 0; i < 17; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      chk("midrst_samples", bus.o_samples, SW'(0));
      chk("midrst_count", SW'(bus.o_byte_count), SW'(0));
      chk("midrst_pulses", SW'({bus.o_timeout, bus.o_overrun, bus.o_frame_valid}), SW'(0));
      send_frame(2);

      // Random traffic, including acks, overruns, rare resets and idle stretches
      for (int c = 0; c < 2000; c++) begin
         logic v, a, r;
         v = ($urandom_range(99) < 45);
         a = ($urandom_range(99) < 20);
         r = ($urandom_range(999) < 2);
         if ((c % 500) > 380 && (c % 500) < 500) v = 1'b0;
         tick(v, 8'($urandom), a, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
Receive-side counterpart of the FFT result serializer. Takes bytes from UART_RX and packs byte pairs, low byte first, into WORD_SIZE-bit samples. It collects FFT_SIZE samples into one frame and presents the frame to the FFT core with a valid/ack handshake. It also detects stalled partial frames with an inter-byte timeout and flags bytes lost while a frame is pending.

Parameters:
FFT_SIZE, 16, samples per frame
WORD_SIZE, 16, bits per sample; must equal 2*DATA_LENGTH
DATA_LENGTH, 8, bits per UART byte
TIMEOUT_CYCLES, 8680, idle clocks (10 bit times at CLOCK_PER_BIT=868) after which a partial frame is discarded

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_byte  in  DATA_LENGTH  received byte
i_byte_valid  in  1  one-cycle strobe; i_byte is valid this cycle
i_frame_ack  in  1  consumer has taken the frame
o_samples  out  FFT_SIZE*WORD_SIZE  flattened frame; sample k at [k*WORD_SIZE +: WORD_SIZE]
o_frame_valid  out  1  a complete frame is held on o_samples
o_byte_count  out  6  bytes accepted in the current frame (0..2*FFT_SIZE-1)
o_timeout  out  1  one-cycle pulse when a partial frame is discarded
o_overrun  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high. All state updates on the rising edge of i_clk.
- Reset values: o_samples=0, o_frame_valid=0, o_byte_count=0, o_timeout=0, o_overrun=0, state=COLLECT, timeout counter=0, low-byte holding register=0.
- States: COLLECT (accepting bytes) and FULL (frame held, waiting for ack).
- Accepting a byte in COLLECT: each cycle with i_byte_valid=1 accepts one byte, and o_byte_count increments the next cycle.
  - Even count: i_byte goes into the low-byte holding register.
  - Odd count n: sample n>>1 is written as {i_byte, low register}. The sample is visible on o_samples the next cycle.
- Frame completion: when byte 2*FFT_SIZE-1 is accepted, the next cycle has o_frame_valid=1, o_byte_count=0 and state=FULL. Latency from last byte strobe to valid is 1 cycle.
- FULL: o_samples is frozen.
  - i_frame_ack=1 returns to COLLECT; o_frame_valid=0 on the next cycle.
  - i_frame_ack is ignored in COLLECT.
- Byte arriving while FULL without ack: the byte is dropped, o_overrun pulses the next cycle, and count and samples are unchanged.
- Byte and ack in the same cycle while FULL: the ack takes priority. The byte is accepted as byte 0 of the new frame, with no overrun. o_samples is guaranteed stable only while o_frame_valid=1, so the consumer latches on ack.
- Timeout:
  - The counter is active only in COLLECT with o_byte_count>0. It clears on every accepted byte and increments otherwise.
  - On reaching TIMEOUT_CYCLES-1: o_byte_count goes to 0 and o_timeout pulses for 1 cycle. Already-written samples are not cleared; they are overwritten by the next frame.
  - A byte arriving in the same cycle as expiry is accepted as byte 0 of the new frame.
- Counter widths: the byte counter wraps from 2*FFT_SIZE-1 to 0 only via frame completion or timeout, never beyond. The timeout counter saturates and cannot overflow.
- Reset mid-frame or while FULL: immediately returns to reset values; a pending frame is lost and there is no timeout/overrun pulse.
- i_byte_valid high for consecutive cycles: each cycle counts as a separate byte, with no throughput limit.

Test Plan:
- Byte-order check: send 32 bytes, byte i = i (0x00..0x1F), one strobe every 10 cycles. Required: o_frame_valid rises 1 cycle after the 32nd strobe; sample0=0x0100, sample1=0x0302, sample15=0x1F1E; o_byte_count=0.
- Frame pending, then ack: hold frame 50 cycles, send 1 byte without ack, then ack. Required: o_overrun pulses once, samples unchanged, valid held 50+ cycles, valid=0 the cycle after ack.
- Simultaneous ack and byte: assert i_frame_ack and i_byte_valid (byte 0xAA) in the same cycle. Required: valid drops, o_byte_count=1, no overrun, next byte 0xBB gives sample0=0xBBAA.
- Timeout: send 5 bytes, then idle with TIMEOUT_CYCLES=100. Required: o_timeout pulses exactly 99 cycles after the 5th strobe and o_byte_count=0; a following 32-byte frame assembles correctly.
- Reset mid-frame: send 17 bytes, assert i_rst 1 cycle. Required: all outputs 0 next cycle; a fresh 32-byte frame completes normally.
- Back-to-back strobes: 32 consecutive strobe cycles with random bytes. Required: valid 1 cycle after the last strobe and all 16 samples match the reference model.
